mem_bus_arbiter: RTL

- Shares one 64-bit system memory port between the instruction-side (ib_*) and data-side (db_*) buses that leave the core/L1 wrapper.
- Per-request round-robin arbitration with grant lock until handshake completes.
- In-order tracking of outstanding reads so response beats return to the originating requester.
- Sits between the core/cache top level and the SoC memory/interconnect.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction and data buses onto one shared memory port and
// steers read response beats back to whichever side issued each read, in order.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_OPEN | no request in flight; a fresh arbitration decision every cycle
// ST_LOCK | presented request not yet accepted; grant frozen on grant_q
module mem_bus_arbiter #(
   parameter int RD_DEPTH    = 4,
   parameter int DB_PRIORITY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ib_req_addr,
   input  logic [2:0]  ib_req_size,
   input  logic        ib_req_valid,
   output logic        ib_req_ready,
   output logic [63:0] ib_resp_rdata,
   output logic        ib_resp_valid,
   input  logic        ib_resp_ready,
   input  logic [31:0] db_req_addr,
   input  logic [63:0] db_req_wdata,
   input  logic [7:0]  db_req_wmask,
   input  logic        db_req_wen,
   input  logic [2:0]  db_req_size,
   input  logic        db_req_valid,
   output logic        db_req_ready,
   output logic [63:0] db_resp_rdata,
   output logic        db_resp_valid,
   input  logic        db_resp_ready,
   output logic [31:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   output logic        mem_req_wen,
   output logic [2:0]  mem_req_size,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   input  logic [63:0] mem_resp_rdata,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready
);

   localparam int AW = $clog2(RD_DEPTH);
   localparam logic SRC_IB = 1'b0;
   localparam logic SRC_DB = 1'b1;

   typedef enum logic {ST_OPEN, ST_LOCK} state_t;

   state_t         state_q, state_d;
   logic           grant_q;
   logic           last_grant_q;
   logic [AW:0]    count_q;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [3:0]     beat_q;
   logic           fifo_src_q   [RD_DEPTH];
   logic [3:0]     fifo_beats_q [RD_DEPTH];

   logic           fifo_full, fifo_empty;
   logic           ib_cand, db_cand;
   logic           sel_src, sel_valid;
   logic           req_hs, push, pop, resp_hs;
   logic           head_src;
   logic [3:0]     head_beats;
   logic [3:0]     req_beats_m1;

   function automatic logic [3:0] beats_m1(input logic [2:0] size);
      case (size)
         3'd4:    return 4'd1;
         3'd5:    return 4'd3;
         3'd6:    return 4'd7;
         3'd7:    return 4'd15;
         default: return 4'd0;
      endcase
   endfunction

   assign fifo_full  = (count_q == (AW+1)'(RD_DEPTH));
   assign fifo_empty = (count_q == '0);

   // Full is judged on registered occupancy, so a same-cycle pop cannot unblock a read.
   assign ib_cand = ib_req_valid && !fifo_full;
   assign db_cand = db_req_valid && (db_req_wen || !fifo_full);

   always_comb begin
      state_d   = state_q;
      sel_src   = grant_q;
      sel_valid = 1'b0;
      case (state_q)
         ST_OPEN: begin
            if (ib_cand && db_cand)
               sel_src = ((DB_PRIORITY != 0) || (last_grant_q == SRC_IB)) ? SRC_DB : SRC_IB;
            else
               sel_src = db_cand ? SRC_DB : SRC_IB;
            sel_valid = ib_cand || db_cand;
         end
         ST_LOCK: begin
            sel_src   = grant_q;
            sel_valid = (grant_q == SRC_DB) ? db_req_valid : ib_req_valid;
         end
         default: begin
            sel_src   = grant_q;
            sel_valid = 1'b0;
         end
      endcase
      sel_valid = sel_valid && !rst;
      state_d   = (sel_valid && !mem_req_ready) ? ST_LOCK : ST_OPEN;
   end

   assign mem_req_addr  = (sel_src == SRC_DB) ? db_req_addr  : ib_req_addr;
   assign mem_req_size  = (sel_src == SRC_DB) ? db_req_size  : ib_req_size;
   assign mem_req_wdata = (sel_src == SRC_DB) ? db_req_wdata : '0;
   assign mem_req_wmask = (sel_src == SRC_DB) ? db_req_wmask : '0;
   assign mem_req_wen   = (sel_src == SRC_DB) && db_req_wen;
   assign mem_req_valid = sel_valid;
   assign ib_req_ready  = sel_valid && (sel_src == SRC_IB) && mem_req_ready;
   assign db_req_ready  = sel_valid && (sel_src == SRC_DB) && mem_req_ready;

   assign req_hs       = sel_valid && mem_req_ready;
   assign push         = req_hs && !mem_req_wen;
   assign req_beats_m1 = beats_m1(mem_req_size);

   assign head_src   = fifo_src_q[rd_ptr_q];
   assign head_beats = fifo_beats_q[rd_ptr_q];

   // Beats arriving with nothing outstanding are never acknowledged.
   assign ib_resp_rdata  = mem_resp_rdata;
   assign db_resp_rdata  = mem_resp_rdata;
   assign ib_resp_valid  = !rst && mem_resp_valid && !fifo_empty && (head_src == SRC_IB);
   assign db_resp_valid  = !rst && mem_resp_valid && !fifo_empty && (head_src == SRC_DB);
   assign mem_resp_ready = !rst && !fifo_empty &&
                           ((head_src == SRC_DB) ? db_resp_ready : ib_resp_ready);

   assign resp_hs = mem_resp_valid && mem_resp_ready;
   assign pop     = resp_hs && (beat_q == head_beats);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_OPEN;
         grant_q      <= SRC_IB;
         last_grant_q <= SRC_DB;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         beat_q       <= '0;
      end else begin
         state_q <= state_d;
         if (sel_valid)
            grant_q <= sel_src;
         if (req_hs)
            last_grant_q <= sel_src;
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
         if (pop)
            beat_q <= '0;
         else if (resp_hs)
            beat_q <= beat_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_src_q[wr_ptr_q]   <= sel_src;
         fifo_beats_q[wr_ptr_q] <= req_beats_m1;
      end
   end

endmodule
